regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter N, default 32, data width in bits of every register and data port.
REQ-002 Parameter A, default 5, address width in bits; register count is 2**A.
REQ-003 CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset; clears all registers.
REQ-005 WE  input  1  write enable; write occurs on rising CLOCK when WE=1.
REQ-006 WA  input  A  write address.
REQ-007 WD  input  N  write data.
REQ-008 RA1  input  A  read address, port 1.
REQ-009 RA2  input  A  read address, port 2.
REQ-010 RD1  output  N  read data, port 1.
REQ-011 RD2  output  N  read data, port 2.

Function
REQ-012 Storage SHALL be 2**A registers of N bits each; register 0 SHALL always read as zero.
REQ-013 On rising CLOCK with WE=1, RESET=0 and WA!=0, register[WA] SHALL take WD; all other registers SHALL hold.
REQ-014 Writes with WA=0 SHALL be discarded with no side effect on any register.
REQ-015 With WE=0, no register SHALL change on any CLOCK edge.
REQ-016 RD1 SHALL equal register[RA1] combinationally (zero-cycle latency from RA1 or stored-value change); same for RD2/RA2.
REQ-017 Read-during-write: before the write edge, RD shows the old value; after the edge settles, RD shows WD (no internal bypass).
REQ-018 RA1 and RA2 SHALL be independent; RA1=RA2 SHALL yield identical RD1 and RD2.
REQ-019 X/Z on WE SHALL not be relied upon; bench drives WE known at all times after reset release.
REQ-020 Address values wrap implicitly at A bits; no out-of-range condition exists.

Reset
REQ-021 RESET=1 SHALL clear every register to 0 immediately, independent of CLOCK.
REQ-022 While RESET=1, writes SHALL be ignored and RD1/RD2 SHALL read 0 for every address.
REQ-023 RESET asserted in the same cycle as a write SHALL win; the written register SHALL be 0 afterwards.
REQ-024 After RESET deasserts, the first rising CLOCK with WE=1 SHALL perform a normal write.

Structure
REQ-025 Shared package regfile_pkg SHALL hold default N and A constants and a typedef for the N-bit word.
REQ-026 Each storage element SHALL be one instance of sub-module dff_en (N-bit D flip-flop with CLOCK, RESET async active-high, EN, D, Q); register 0 SHALL have no instance and drive constant zero.
REQ-027 Write decode SHALL generate one EN per register from WE and WA; read paths SHALL be two independent multiplexers.

Verification
REQ-028 Reset then read all addresses on both ports -> RD1=RD2=0x00000000 for all 32 addresses.
REQ-029 Write 0xDEADBEEF to 5, 0x00000001 to 31; read RA1=5, RA2=31 -> RD1=0xDEADBEEF, RD2=0x00000001.
REQ-030 Write 0xFFFFFFFF to address 0; read RA1=0 -> RD1=0x00000000, no other register changed.
REQ-031 WE=0 with WA=7, WD=0x12345678 over 3 edges -> register 7 remains previous value (0 after reset).
REQ-032 Write 0xA5A5A5A5 to 9 with RA1=9: before edge RD1=old value, after edge RD1=0xA5A5A5A5.
REQ-033 Write 0x0000BEEF to 3, assert RESET mid-cycle between edges -> RD1 at RA1=3 drops to 0 before next CLOCK edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file slice.
package regfile_pkg;
   localparam int N_DEF = 32;
   localparam int A_DEF = 5;

   typedef logic [N_DEF-1:0] word_t;
endpackage

// File: rtl/regfile_dff_en.sv
// N-bit enabled D flip-flop with asynchronous active-high clear; one per register.
module dff_en
   import regfile_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         CLOCK,
   input  logic         RESET,
   input  logic         EN,
   input  logic [N-1:0] D,
   output logic [N-1:0] Q
);

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         Q <= '0;
      end else if (EN) begin
         Q <= D;
      end
   end

endmodule

// File: rtl/regfile.sv
// 2**A x N register file: one write port, two combinational read ports, register 0 hardwired to zero.
module regfile
   import regfile_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int A = A_DEF
) (
   input  logic         CLOCK,
   input  logic         RESET,
   input  logic         WE,
   input  logic [A-1:0] WA,
   input  logic [N-1:0] WD,
   input  logic [A-1:0] RA1,
   input  logic [A-1:0] RA2,
   output logic [N-1:0] RD1,
   output logic [N-1:0] RD2
);

   localparam int DEPTH = 2**A;

   logic [N-1:0]       regs [DEPTH];
   logic [DEPTH-1:1]   en;

   assign regs[0] = '0;

   // Register 0 has no storage, so the decode starts at index 1 and a write to 0 falls through.
   for (genvar i = 1; i < DEPTH; i++) begin : g_reg
      localparam logic [A-1:0] IDX = A'(i);

      assign en[i] = WE && (WA == IDX);

      dff_en #(.N(N)) u_dff (
         .CLOCK (CLOCK),
         .RESET (RESET),
         .EN    (en[i]),
         .D     (WD),
         .Q     (regs[i])
      );
   end

   // Independent read muxes with no write bypass: a write shows up only once the flop updates.
   assign RD1 = regs[RA1];
   assign RD2 = regs[RA2];

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, writes, address-0 discard, read-during-write, async reset.
module tb_regfile;
   import regfile_pkg::*;

   logic        CLOCK;
   logic        RESET;
   logic        WE;
   logic [4:0]  WA;
   logic [31:0] WD;
   logic [4:0]  RA1;
   logic [4:0]  RA2;
   logic [31:0] RD1;
   logic [31:0] RD2;

   word_t mdl [32];
   int    total;
   int    bad;

   regfile #(.N(32), .A(5)) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .WE    (WE),
      .WA    (WA),
      .WD    (WD),
      .RA1   (RA1),
      .RA2   (RA2),
      .RD1   (RD1),
      .RD2   (RD2)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge CLOCK);
      WE = 1'b1;
      WA = a;
      WD = d;
      @(posedge CLOCK);
      #1;
      WE = 1'b0;
      if (a != 5'd0) mdl[a] = d;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 32; i++) begin
         RA1 = 5'(i);
         RA2 = 5'((i + 7) % 32);
         #1;
         chk($sformatf("%s_rd1_a%0d", tag, i), RD1, mdl[i]);
         chk($sformatf("%s_rd2_a%0d", tag, (i + 7) % 32), RD2, mdl[(i + 7) % 32]);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      RESET = 1'b1;
      WE    = 1'b0;
      WA    = '0;
      WD    = '0;
      RA1   = '0;
      RA2   = '0;

      // Writes attempted while reset is held must be ignored
      @(negedge CLOCK);
      WE = 1'b1;
      WA = 5'd4;
      WD = 32'hFFFF_FFFF;
      @(posedge CLOCK);
      #1;
      RA1 = 5'd4;
      RA2 = 5'd17;
      #1;
      chk("in_reset_rd1", RD1, 32'h0);
      chk("in_reset_rd2", RD2, 32'h0);

      @(negedge CLOCK);
      WE    = 1'b0;
      RESET = 1'b0;
      check_all("post_reset");

      // WE low for three edges: register 7 stays at its reset value
      @(negedge CLOCK);
      WE = 1'b0;
      WA = 5'd7;
      WD = 32'h1234_5678;
      repeat (3) @(posedge CLOCK);
      #1;
      RA1 = 5'd7;
      #1;
      chk("we_low_r7", RD1, 32'h0);

      wr(5'd5, 32'hDEAD_BEEF);
      wr(5'd31, 32'h0000_0001);
      RA1 = 5'd5;
      RA2 = 5'd31;
      #1;
      chk("w5_rd1", RD1, 32'hDEAD_BEEF);
      chk("w31_rd2", RD2, 32'h0000_0001);
      RA2 = 5'd5;
      #1;
      chk("same_addr", RD2, RD1);
      chk("same_addr_val", RD2, 32'hDEAD_BEEF);

      // Distinct value per register exposes any decode aliasing
      for (int i = 1; i < 32; i++) begin
         wr(5'(i), 32'h0101_0101 * i ^ 32'h5A00_0000);
      end
      check_all("fill");

      wr(5'd0, 32'hFFFF_FFFF);
      check_all("w0_discard");

      // Read-during-write on register 9
      @(negedge CLOCK);
      RA1 = 5'd9;
      WE  = 1'b1;
      WA  = 5'd9;
      WD  = 32'hA5A5_A5A5;
      #1;
      chk("rdw_before", RD1, mdl[9]);
      @(posedge CLOCK);
      #1;
      chk("rdw_after", RD1, 32'hA5A5_A5A5);
      WE = 1'b0;
      mdl[9] = 32'hA5A5_A5A5;

      // Async reset mid-cycle clears before the next edge
      wr(5'd3, 32'h0000_BEEF);
      RA1 = 5'd3;
      RA2 = 5'd9;
      #1;
      chk("r3_beef", RD1, 32'h0000_BEEF);
      @(posedge CLOCK);
      #2;
      RESET = 1'b1;
      #1;
      chk("async_rst_r3", RD1, 32'h0);
      chk("async_rst_r9", RD2, 32'h0);
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      @(negedge CLOCK);
      RESET = 1'b0;

      // Reset coinciding with a write wins
      wr(5'd3, 32'h0000_1234);
      @(negedge CLOCK);
      WE    = 1'b1;
      WA    = 5'd3;
      WD    = 32'h0000_CAFE;
      RESET = 1'b1;
      @(posedge CLOCK);
      #1;
      RA1 = 5'd3;
      #1;
      chk("rst_wins", RD1, 32'h0);
      mdl[3] = '0;
      @(negedge CLOCK);
      WE    = 1'b0;
      RESET = 1'b0;

      // First write after reset release is a normal write
      wr(5'd3, 32'h0000_600D);
      RA1 = 5'd3;
      #1;
      chk("first_wr", RD1, 32'h0000_600D);
      check_all("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
